// File: rtl/uart_rx.sv
// UART receiver: synchronized line, mid-bit sampling FSM, 5-8 data bits, optional even parity,
// one or two stop bits, single-word holding register with ready/valid handshake and overrun pulse.
module uart_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx_i,
  input  logic        cfg_en_i,
  input  logic [15:0] cfg_div_i,
  input  logic        cfg_parity_en_i,
  input  logic [1:0]  cfg_bits_i,
  input  logic        cfg_stop_bits_i,
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic        parity_err_o,
  output logic        frame_err_o,
  output logic        overrun_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sync_q, flush_q;
  logic rxs, rxs_d, armed, start_edge;

  // armed only after the synchronizer has flushed and the real line was seen high,
  // so a line held low through reset never looks like a start edge
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= '1;
      flush_q <= '0;
      rxs_d   <= 1'b1;
      armed   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], rx_i};
      flush_q <= {flush_q[SYNC_STAGES-2:0], 1'b1};
      rxs_d   <= rxs;
      if (flush_q[SYNC_STAGES-1] && rxs) armed <= 1'b1;
    end
  end

  assign rxs        = sync_q[SYNC_STAGES-1];
  assign start_edge = armed & rxs_d & ~rxs & cfg_en_i;

  logic [15:0] div_eff, div_q, cnt;
  logic        tick, last;
  logic [2:0]  bit_idx, nbits_q;
  logic        par_en_q, stop2_q, stop_idx;
  logic [7:0]  shreg;
  logic        par_acc, perr, ferr, done;

  assign div_eff = (cfg_div_i < 16'd2) ? 16'd2 : cfg_div_i;
  assign tick    = (cnt == 16'd1);
  assign busy_o  = (state != IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    last      = 1'b0;
    if (!cfg_en_i) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start_edge) state_nxt = START;
        START:   if (tick) state_nxt = rxs ? IDLE : DATA;
        DATA:    if (tick && bit_idx == nbits_q) state_nxt = par_en_q ? PARITY : STOP;
        PARITY:  if (tick) state_nxt = STOP;
        STOP:    if (tick && (stop_idx || !stop2_q)) begin
                   state_nxt = IDLE;
                   last      = 1'b1;
                 end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // bit timing and frame assembly; cfg is latched at the start edge only
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt      <= '0;
      div_q    <= 16'd2;
      nbits_q  <= '0;
      par_en_q <= 1'b0;
      stop2_q  <= 1'b0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      par_acc  <= 1'b0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= last;
      if (state == IDLE) begin
        if (start_edge) begin
          div_q    <= div_eff;
          cnt      <= div_eff >> 1;
          nbits_q  <= {1'b1, cfg_bits_i};
          par_en_q <= cfg_parity_en_i;
          stop2_q  <= cfg_stop_bits_i;
          bit_idx  <= '0;
          stop_idx <= 1'b0;
          shreg    <= '0;
          par_acc  <= 1'b0;
          perr     <= 1'b0;
          ferr     <= 1'b0;
        end
      end else if (tick) begin
        cnt <= div_q;
        case (state)
          DATA: begin
            shreg[bit_idx] <= rxs;
            par_acc        <= par_acc ^ rxs;
            bit_idx        <= bit_idx + 3'd1;
          end
          PARITY: perr <= rxs ^ par_acc;
          STOP: begin
            if (!rxs) ferr <= 1'b1;
            stop_idx <= 1'b1;
          end
          default: ;
        endcase
      end else begin
        cnt <= cnt - 16'd1;
      end
    end
  end

  // holding register: a completed frame loads when the slot is free or being accepted now
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_data_o    <= '0;
      rx_valid_o   <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      overrun_o <= 1'b0;
      if (rx_valid_o && rx_ready_i) rx_valid_o <= 1'b0;
      if (done) begin
        if (!rx_valid_o || rx_ready_i) begin
          rx_data_o    <= shreg;
          parity_err_o <= perr;
          frame_err_o  <= ferr;
          rx_valid_o   <= 1'b1;
        end else begin
          overrun_o <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frame formats, error flags, glitch rejection, backpressure,
// enable abort and asynchronous reset abort.
module tb_uart_rx;
  localparam int DIV = 16;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        rx_i = 1'b1;
  logic        cfg_en_i = 1'b1;
  logic [15:0] cfg_div_i = DIV;
  logic        cfg_parity_en_i = 1'b0;
  logic [1:0]  cfg_bits_i = 2'b11;
  logic        cfg_stop_bits_i = 1'b0;
  logic [7:0]  rx_data_o;
  logic        rx_valid_o;
  logic        rx_ready_i = 1'b0;
  logic        parity_err_o, frame_err_o, overrun_o, busy_o;

  int checks = 0;
  int errors = 0;

  uart_rx #(.SYNC_STAGES(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .rx_i(rx_i), .cfg_en_i(cfg_en_i), .cfg_div_i(cfg_div_i),
    .cfg_parity_en_i(cfg_parity_en_i), .cfg_bits_i(cfg_bits_i), .cfg_stop_bits_i(cfg_stop_bits_i),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
    .parity_err_o(parity_err_o), .frame_err_o(frame_err_o), .overrun_o(overrun_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // edge counter plus event log: busy/valid rise times, valid rises, overrun pulse cycles
  int   cyc = 0, t_busy = 0, t_valid = 0, n_valid = 0, n_ovr = 0;
  logic busy_q = 1'b0, valid_q = 1'b0;
  always @(posedge clk_i) cyc++;
  always @(negedge clk_i) begin
    if (busy_o && !busy_q) t_busy = cyc;
    if (rx_valid_o && !valid_q) begin
      t_valid = cyc;
      n_valid++;
    end
    if (overrun_o) n_ovr++;
    busy_q  = busy_o;
    valid_q = rx_valid_o;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic set_cfg(input int nb, input bit par, input bit stop2);
    cfg_bits_i      = 2'(nb - 5);
    cfg_parity_en_i = par;
    cfg_stop_bits_i = stop2;
  endtask

  task automatic send_frame(input logic [7:0] d, input int nb, input bit par_on, input bit par_bit,
                            input int nstop, input bit stop_val);
    rx_i = 1'b0;
    cycles(DIV);
    for (int i = 0; i < nb; i++) begin
      rx_i = d[i];
      cycles(DIV);
    end
    if (par_on) begin
      rx_i = par_bit;
      cycles(DIV);
    end
    for (int i = 0; i < nstop; i++) begin
      rx_i = stop_val;
      cycles(DIV);
    end
    rx_i = 1'b1;
    cycles(DIV);
  endtask

  task automatic accept();
    rx_ready_i = 1'b1;
    cycles(1);
    rx_ready_i = 1'b0;
    chk("valid_clear", {31'd0, rx_valid_o}, 32'd0);
  endtask

  int nv, no;

  initial begin
    // reset state
    cycles(3);
    chk("rst_data", {24'd0, rx_data_o}, 32'h00);
    chk("rst_valid", {31'd0, rx_valid_o}, 32'd0);
    chk("rst_perr", {31'd0, parity_err_o}, 32'd0);
    chk("rst_ferr", {31'd0, frame_err_o}, 32'd0);
    chk("rst_ovr", {31'd0, overrun_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    rst_i = 1'b0;
    cycles(10);

    // basic 8E2 frame: 0x08 with parity bit 1; start edge to valid is 185 cycles
    set_cfg(8, 1, 1);
    send_frame(8'h08, 8, 1, 1'b1, 2, 1'b1);
    chk("basic_valid", {31'd0, rx_valid_o}, 32'd1);
    chk("basic_data", {24'd0, rx_data_o}, 32'h08);
    chk("basic_perr", {31'd0, parity_err_o}, 32'd0);
    chk("basic_ferr", {31'd0, frame_err_o}, 32'd0);
    chk("basic_latency", t_valid - t_busy, 32'd185);
    accept();

    // short frames
    set_cfg(5, 0, 0);
    send_frame(8'h1F, 5, 0, 1'b0, 1, 1'b1);
    chk("bits5_data", {24'd0, rx_data_o}, 32'h1F);
    accept();
    set_cfg(7, 0, 0);
    send_frame(8'h55, 7, 0, 1'b0, 1, 1'b1);
    chk("bits7_data", {24'd0, rx_data_o}, 32'h55);
    chk("bits7_msb", {31'd0, rx_data_o[7]}, 32'd0);
    accept();

    // parity error: 0xA5 has even bit count, so a 1 parity bit is wrong
    set_cfg(8, 1, 0);
    send_frame(8'hA5, 8, 1, 1'b1, 1, 1'b1);
    chk("perr_data", {24'd0, rx_data_o}, 32'hA5);
    chk("perr_flag", {31'd0, parity_err_o}, 32'd1);
    chk("perr_ferr", {31'd0, frame_err_o}, 32'd0);
    accept();

    // frame error: stop bit low
    set_cfg(8, 0, 0);
    send_frame(8'h3C, 8, 0, 1'b0, 1, 1'b0);
    chk("ferr_data", {24'd0, rx_data_o}, 32'h3C);
    chk("ferr_flag", {31'd0, frame_err_o}, 32'd1);
    chk("ferr_perr", {31'd0, parity_err_o}, 32'd0);
    accept();

    // glitch: 3-cycle low pulse is rejected at mid start bit
    nv = n_valid;
    rx_i = 1'b0;
    cycles(3);
    rx_i = 1'b1;
    cycles(3 * DIV);
    chk("glitch_busy", {31'd0, busy_o}, 32'd0);
    chk("glitch_novalid", n_valid - nv, 32'd0);

    // backpressure: second frame dropped, first kept, one overrun pulse
    no = n_ovr;
    send_frame(8'h11, 8, 0, 1'b0, 1, 1'b1);
    chk("bp_first", {24'd0, rx_data_o}, 32'h11);
    send_frame(8'h22, 8, 0, 1'b0, 1, 1'b1);
    chk("bp_kept", {24'd0, rx_data_o}, 32'h11);
    chk("bp_valid", {31'd0, rx_valid_o}, 32'd1);
    chk("bp_ovr_pulses", n_ovr - no, 32'd1);

    // enable drop mid-frame aborts it without touching the held word
    nv = n_valid;
    rx_i = 1'b0;
    cycles(DIV);
    rx_i = 1'b1;
    cycles(DIV + 4);
    cfg_en_i = 1'b0;
    cycles(1);
    chk("en_abort_busy", {31'd0, busy_o}, 32'd0);
    cycles(8 * DIV);
    cfg_en_i = 1'b1;
    cycles(2 * DIV);
    chk("en_abort_novalid", n_valid - nv, 32'd0);
    chk("en_abort_data", {24'd0, rx_data_o}, 32'h11);
    chk("en_abort_valid", {31'd0, rx_valid_o}, 32'd1);
    accept();

    // reset mid-DATA with a word held: outputs clear at once
    send_frame(8'h99, 8, 0, 1'b0, 1, 1'b1);
    chk("pre_rst_valid", {31'd0, rx_valid_o}, 32'd1);
    rx_i = 1'b0;
    cycles(DIV);
    rx_i = 1'b1;
    cycles(DIV);
    rx_i = 1'b0;
    cycles(5);
    #3 rst_i = 1'b1;
    #1;
    chk("arst_data", {24'd0, rx_data_o}, 32'h00);
    chk("arst_valid", {31'd0, rx_valid_o}, 32'd0);
    chk("arst_perr", {31'd0, parity_err_o}, 32'd0);
    chk("arst_ferr", {31'd0, frame_err_o}, 32'd0);
    chk("arst_ovr", {31'd0, overrun_o}, 32'd0);
    chk("arst_busy", {31'd0, busy_o}, 32'd0);
    cycles(2);
    rst_i = 1'b0;
    // line still low after reset: no start until a 1->0 transition
    cycles(3 * DIV);
    chk("low_after_rst_busy", {31'd0, busy_o}, 32'd0);
    chk("low_after_rst_valid", {31'd0, rx_valid_o}, 32'd0);
    rx_i = 1'b1;
    cycles(DIV);
    send_frame(8'hC3, 8, 0, 1'b0, 1, 1'b1);
    chk("post_rst_valid", {31'd0, rx_valid_o}, 32'd1);
    chk("post_rst_data", {24'd0, rx_data_o}, 32'hC3);
    accept();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // hard bound on run time
  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
